// File: rtl/axis_monitor.sv
// Passive AXI-Stream monitor: per-TDEST open-packet byte counters, completed
// packet count, stall tracking and sticky protocol error flags.
module axis_monitor #(
    parameter int DW         = 32,
    parameter int DESTW      = 2,
    parameter int LGPKT      = 16,
    parameter int MAX_PACKET = 0,
    parameter int MIN_PACKET = 0,
    parameter int MAX_STALL  = 0,
    localparam int TW        = (DESTW > 0) ? DESTW : 1,
    localparam int SCW       = $clog2(MAX_STALL + 2)
) (
    input  logic             i_aclk,
    input  logic             i_areset,
    input  logic             i_tvalid,
    input  logic             i_tready,
    input  logic [DW-1:0]    i_tdata,
    input  logic [DW/8-1:0]  i_tstrb,
    input  logic [DW/8-1:0]  i_tkeep,
    input  logic             i_tlast,
    input  logic [TW-1:0]    i_tdest,
    input  logic             i_clear,
    input  logic [TW-1:0]    i_sel,
    output logic [LGPKT-1:0] o_bytecount,
    output logic [31:0]      o_npackets,
    output logic [5:0]       o_err,
    output logic [2:0]       o_first_err,
    output logic [TW-1:0]    o_first_dest,
    output logic [SCW-1:0]   o_stall_count
);

    localparam int NB  = DW / 8;
    localparam int NCH = 1 << DESTW;
    localparam int VBW = $clog2(NB + 1);
    localparam int SW  = LGPKT + 1;

    // With DESTW=0 the mask is zero, so TDEST and the select collapse onto channel 0.
    localparam logic [TW-1:0]  DMASK     = TW'(NCH - 1);
    localparam logic [SW-1:0]  MAXP      = SW'(MAX_PACKET);
    localparam logic [SW-1:0]  MINP      = SW'(MIN_PACKET);
    localparam logic [SCW-1:0] STALL_LIM = SCW'(MAX_STALL);

    logic [LGPKT-1:0] counter [NCH];
    logic [TW-1:0]    dest_idx;
    logic [TW-1:0]    sel_idx;
    logic [VBW-1:0]   vbytes;
    logic [SW-1:0]    pkt_sum;
    logic [LGPKT-1:0] sat_sum;
    logic             data_changed;
    logic [5:0]       new_err;
    logic [2:0]       first_code;

    // Payload of the previous cycle, kept so a stalled beat can be checked for stability.
    logic             prev_stall;
    logic [DW-1:0]    prev_tdata;
    logic [NB-1:0]    prev_tstrb;
    logic [NB-1:0]    prev_tkeep;
    logic             prev_tlast;
    logic [TW-1:0]    prev_dest;
    logic             first_edge;

    assign dest_idx    = i_tdest & DMASK;
    assign sel_idx     = i_sel & DMASK;
    assign o_bytecount = counter[sel_idx];

    // The sum carries one extra bit so a saturated counter still compares correctly.
    assign pkt_sum = {1'b0, counter[dest_idx]} + SW'(vbytes);
    assign sat_sum = pkt_sum[LGPKT] ? '1 : pkt_sum[LGPKT-1:0];

    // Count the lanes that carry real data bytes on this beat.
    always_comb begin
        vbytes = '0;
        if (i_tvalid) begin
            for (int i = 0; i < NB; i++) begin
                vbytes = vbytes + VBW'(i_tkeep[i] & i_tstrb[i]);
            end
        end
    end

    // Flag any kept byte whose data moved since the previous cycle.
    always_comb begin
        data_changed = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (i_tkeep[i] && (i_tdata[8*i +: 8] != prev_tdata[8*i +: 8])) begin
                data_changed = 1'b1;
            end
        end
    end

    // Error conditions seen in the current cycle; they are latched on the next edge.
    always_comb begin
        new_err    = '0;
        new_err[0] = prev_stall && (!i_tvalid || (i_tstrb != prev_tstrb) ||
                     (i_tkeep != prev_tkeep) || (i_tlast != prev_tlast) ||
                     (dest_idx != prev_dest) || data_changed);
        new_err[1] = i_tvalid && (|(i_tstrb & ~i_tkeep));
        new_err[2] = (MAX_PACKET > 0) && i_tvalid && (pkt_sum > MAXP);
        new_err[3] = (MIN_PACKET > 0) && i_tvalid && i_tlast && (pkt_sum < MINP);
        new_err[4] = (MAX_STALL > 0) && (o_stall_count == STALL_LIM);
        new_err[5] = first_edge && i_tvalid;
    end

    // Lowest-numbered simultaneous error wins the first-error code.
    always_comb begin
        first_code = '0;
        for (int i = 5; i >= 0; i--) begin
            if (new_err[i]) first_code = 3'(i);
        end
    end

    // Per-channel byte counters and the completed-packet count.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            for (int i = 0; i < NCH; i++) counter[i] <= '0;
            o_npackets <= '0;
        end else if (i_tvalid && i_tready) begin
            if (i_tlast) begin
                counter[dest_idx] <= '0;
                o_npackets        <= o_npackets + 32'd1;
            end else begin
                counter[dest_idx] <= sat_sum;
            end
        end
    end

    // Consecutive stall counter plus the prior-beat snapshot for the stability check.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            o_stall_count <= '0;
            prev_stall    <= 1'b0;
            prev_tdata    <= '0;
            prev_tstrb    <= '0;
            prev_tkeep    <= '0;
            prev_tlast    <= 1'b0;
            prev_dest     <= '0;
            first_edge    <= 1'b1;
        end else begin
            if (!i_tvalid || i_tready) begin
                o_stall_count <= '0;
            end else if (o_stall_count != '1) begin
                o_stall_count <= o_stall_count + SCW'(1);
            end
            prev_stall <= i_tvalid && !i_tready;
            prev_tdata <= i_tdata;
            prev_tstrb <= i_tstrb;
            prev_tkeep <= i_tkeep;
            prev_tlast <= i_tlast;
            prev_dest  <= dest_idx;
            first_edge <= 1'b0;
        end
    end

    // Sticky error flags; a clear never masks an error arriving in the same cycle.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            o_err        <= '0;
            o_first_err  <= '0;
            o_first_dest <= '0;
        end else begin
            o_err <= (i_clear ? 6'b0 : o_err) | new_err;
            if ((o_err == '0) || i_clear) begin
                o_first_err  <= first_code;
                o_first_dest <= (new_err != '0) ? dest_idx : '0;
            end
        end
    end

endmodule

// File: tb/tb_axis_monitor.sv
// Self-checking bench for axis_monitor: a default instance and one with packet
// and stall limits, driven by the same stream and compared to a reference model.
module tb_axis_monitor;

    typedef struct {
        logic        tvalid;
        logic        tready;
        logic [31:0] tdata;
        logic [3:0]  tkeep;
        logic [3:0]  tstrb;
        logic        tlast;
        logic [1:0]  tdest;
        logic        clear;
        logic [1:0]  sel;
    } stim_t;

    typedef struct {
        stim_t      in;
        int         exp_bc;
        int         exp_npk;
        logic [5:0] exp_err;
    } vec_t;

    logic        i_aclk = 1'b0;
    logic        i_areset;
    logic        i_tvalid, i_tready, i_tlast, i_clear;
    logic [31:0] i_tdata;
    logic [3:0]  i_tstrb, i_tkeep;
    logic [1:0]  i_tdest, i_sel;

    logic [15:0] d0_bc, l_bc;
    logic [31:0] d0_npk, l_npk;
    logic [5:0]  d0_err, l_err;
    logic [2:0]  d0_ferr, l_ferr;
    logic [1:0]  d0_fdest, l_fdest;
    logic [0:0]  d0_stall;
    logic [2:0]  l_stall;

    int checks = 0;
    int errors = 0;

    // Reference model state: shared stream view plus per-instance error/stall view.
    int          m_cnt [4];
    int unsigned m_npk;
    bit          m_prev_stall;
    stim_t       m_prev;
    bit          m_first;
    int          m_stall [2];
    logic [5:0]  m_err [2];
    int          m_ferr [2];
    int          m_fdest [2];
    int          maxp [2]  = '{0, 8};
    int          minp [2]  = '{0, 2};
    int          maxst [2] = '{0, 3};
    int          scap [2]  = '{1, 7};

    stim_t stim;
    vec_t  vecs [7];

    axis_monitor u_dut (
        .i_aclk(i_aclk), .i_areset(i_areset), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .i_tdata(i_tdata), .i_tstrb(i_tstrb), .i_tkeep(i_tkeep), .i_tlast(i_tlast),
        .i_tdest(i_tdest), .i_clear(i_clear), .i_sel(i_sel),
        .o_bytecount(d0_bc), .o_npackets(d0_npk), .o_err(d0_err),
        .o_first_err(d0_ferr), .o_first_dest(d0_fdest), .o_stall_count(d0_stall)
    );

    axis_monitor #(.MAX_PACKET(8), .MIN_PACKET(2), .MAX_STALL(3)) u_lim (
        .i_aclk(i_aclk), .i_areset(i_areset), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .i_tdata(i_tdata), .i_tstrb(i_tstrb), .i_tkeep(i_tkeep), .i_tlast(i_tlast),
        .i_tdest(i_tdest), .i_clear(i_clear), .i_sel(i_sel),
        .o_bytecount(l_bc), .o_npackets(l_npk), .o_err(l_err),
        .o_first_err(l_ferr), .o_first_dest(l_fdest), .o_stall_count(l_stall)
    );

    always #5 i_aclk = ~i_aclk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired before the test completed");
        $fatal(1, "[TB] watchdog");
    end

    function automatic stim_t mk(input logic v, input logic r, input logic [31:0] d,
                                 input logic [3:0] k, input logic [3:0] s, input logic l,
                                 input logic [1:0] dst, input logic clr, input logic [1:0] sel);
        stim_t t;
        t.tvalid = v; t.tready = r; t.tdata = d; t.tkeep = k; t.tstrb = s;
        t.tlast = l; t.tdest = dst; t.clear = clr; t.sel = sel;
        return t;
    endfunction

    function automatic stim_t idle(input logic clr);
        return mk(1'b0, 1'b1, 32'h0, 4'h0, 4'h0, 1'b0, 2'd0, clr, 2'd0);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        i_tvalid = s.tvalid; i_tready = s.tready; i_tdata = s.tdata;
        i_tkeep = s.tkeep; i_tstrb = s.tstrb; i_tlast = s.tlast;
        i_tdest = s.tdest; i_clear = s.clear; i_sel = s.sel;
    endtask

    task automatic modelReset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_npk = 0;
        m_prev_stall = 0;
        m_prev = idle(1'b0);
        m_first = 1;
        for (int k = 0; k < 2; k++) begin
            m_stall[k] = 0; m_err[k] = '0; m_ferr[k] = 0; m_fdest[k] = 0;
        end
    endtask

    // Advance the model by one clock edge using the stimulus currently applied.
    task automatic stepModel();
        int vb, d, sum;
        bit stable, resv;
        logic [5:0] ne;
        vb = 0;
        if (stim.tvalid) for (int i = 0; i < 4; i++) if (stim.tkeep[i] && stim.tstrb[i]) vb++;
        d = int'(stim.tdest);
        sum = m_cnt[d] + vb;
        stable = 0;
        if (m_prev_stall) begin
            if (!stim.tvalid || stim.tstrb != m_prev.tstrb || stim.tkeep != m_prev.tkeep ||
                stim.tlast != m_prev.tlast || stim.tdest != m_prev.tdest) stable = 1;
            for (int i = 0; i < 4; i++)
                if (stim.tkeep[i] && stim.tdata[8*i +: 8] != m_prev.tdata[8*i +: 8]) stable = 1;
        end
        resv = stim.tvalid && ((stim.tstrb & ~stim.tkeep) != 4'h0);
        for (int k = 0; k < 2; k++) begin
            ne    = '0;
            ne[0] = stable;
            ne[1] = resv;
            ne[2] = maxp[k] > 0 && stim.tvalid && sum > maxp[k];
            ne[3] = minp[k] > 0 && stim.tvalid && stim.tlast && sum < minp[k];
            ne[4] = maxst[k] > 0 && m_stall[k] == maxst[k];
            ne[5] = m_first && stim.tvalid;
            if (m_err[k] == 6'b0 || stim.clear) begin
                m_ferr[k] = 0; m_fdest[k] = 0;
                for (int b = 5; b >= 0; b--) if (ne[b]) begin m_ferr[k] = b; m_fdest[k] = d; end
            end
            m_err[k] = (stim.clear ? 6'b0 : m_err[k]) | ne;
            if (stim.tvalid && !stim.tready) m_stall[k] = (m_stall[k] < scap[k]) ? m_stall[k] + 1 : scap[k];
            else m_stall[k] = 0;
        end
        if (stim.tvalid && stim.tready) begin
            if (stim.tlast) begin m_cnt[d] = 0; m_npk++; end
            else m_cnt[d] = (sum > 65535) ? 65535 : sum;
        end
        m_prev_stall = stim.tvalid && !stim.tready;
        m_prev = stim;
        m_first = 0;
    endtask

    task automatic checkAll();
        checkOutput("d0.bytecount", 64'(d0_bc), 64'(m_cnt[i_sel]));
        checkOutput("d0.npackets", 64'(d0_npk), 64'(m_npk));
        checkOutput("d0.err", 64'(d0_err), 64'(m_err[0]));
        checkOutput("d0.first_err", 64'(d0_ferr), 64'(m_ferr[0]));
        checkOutput("d0.first_dest", 64'(d0_fdest), 64'(m_fdest[0]));
        checkOutput("d0.stall", 64'(d0_stall), 64'(m_stall[0]));
        checkOutput("lim.bytecount", 64'(l_bc), 64'(m_cnt[i_sel]));
        checkOutput("lim.npackets", 64'(l_npk), 64'(m_npk));
        checkOutput("lim.err", 64'(l_err), 64'(m_err[1]));
        checkOutput("lim.first_err", 64'(l_ferr), 64'(m_ferr[1]));
        checkOutput("lim.first_dest", 64'(l_fdest), 64'(m_fdest[1]));
        checkOutput("lim.stall", 64'(l_stall), 64'(m_stall[1]));
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, ".d0"}, {d0_bc, d0_npk, d0_err, d0_ferr, d0_fdest, d0_stall}, 64'h0);
        checkOutput({tag, ".lim"}, {l_bc, l_npk, l_err, l_ferr, l_fdest, l_stall}, 64'h0);
    endtask

    // One clock: drive at the falling edge, step the model, sample just after the rising edge.
    task automatic cycle();
        @(negedge i_aclk);
        applyStimulus(stim);
        stepModel();
        @(posedge i_aclk);
        #1;
        checkAll();
    endtask

    // Asynchronous reset taken between edges; outputs must clear without a clock.
    task automatic resetDut();
        i_areset = 1'b1;
        #1;
        checkZero("async_reset");
        modelReset();
        @(posedge i_aclk);
        #1;
        i_areset = 1'b0;
    endtask

    task automatic randomStim();
        stim_t s;
        if (m_prev_stall && $urandom_range(9) < 8) begin
            s = m_prev;
        end else begin
            s.tvalid = ($urandom_range(9) < 7);
            s.tdata  = $urandom;
            s.tkeep  = 4'($urandom);
            s.tstrb  = ($urandom_range(9) == 0) ? 4'($urandom) : s.tkeep;
            s.tlast  = ($urandom_range(4) == 0);
            s.tdest  = 2'($urandom_range(3));
        end
        s.tready = 1'($urandom_range(1));
        s.clear  = ($urandom_range(19) == 0);
        s.sel    = 2'($urandom_range(3));
        stim = s;
    endtask

    initial begin
        vecs[0] = '{mk(1'b1, 1'b1, 32'hA0A1A2A3, 4'hF, 4'hF, 1'b0, 2'd1, 1'b0, 2'd1), 4, 0, 6'h00};
        vecs[1] = '{mk(1'b1, 1'b1, 32'hB0B1B2B3, 4'hF, 4'hF, 1'b0, 2'd1, 1'b0, 2'd1), 8, 0, 6'h00};
        vecs[2] = '{mk(1'b1, 1'b1, 32'hC0C1C2C3, 4'hF, 4'hF, 1'b1, 2'd1, 1'b0, 2'd1), 0, 1, 6'h00};
        vecs[3] = '{mk(1'b1, 1'b1, 32'h01020304, 4'hF, 4'h3, 1'b0, 2'd1, 1'b0, 2'd1), 2, 1, 6'h00};
        vecs[4] = '{mk(1'b0, 1'b1, 32'h05060708, 4'hF, 4'hF, 1'b0, 2'd1, 1'b0, 2'd1), 2, 1, 6'h00};
        vecs[5] = '{mk(1'b1, 1'b1, 32'h090A0B0C, 4'h6, 4'h6, 1'b0, 2'd1, 1'b0, 2'd1), 4, 1, 6'h00};
        vecs[6] = '{mk(1'b1, 1'b1, 32'h0D0E0F10, 4'hF, 4'hF, 1'b1, 2'd1, 1'b0, 2'd1), 0, 2, 6'h00};

        i_areset = 1'b0;
        stim = idle(1'b0);
        applyStimulus(stim);
        #1 i_areset = 1'b1;
        modelReset();
        @(posedge i_aclk);
        #1;
        checkZero("reset");
        i_areset = 1'b0;
        stim = idle(1'b0);
        cycle();

        // Table: packet on channel 1 plus partial-lane and idle beats.
        for (int i = 0; i < 7; i++) begin
            stim = vecs[i].in;
            cycle();
            checkOutput($sformatf("vec%0d.bytecount", i), 64'(d0_bc), 64'(vecs[i].exp_bc));
            checkOutput($sformatf("vec%0d.npackets", i), 64'(d0_npk), 64'(vecs[i].exp_npk));
            checkOutput($sformatf("vec%0d.err", i), 64'(d0_err), 64'(vecs[i].exp_err));
        end
        stim = idle(1'b1);
        cycle();

        // Stalled beat whose kept data changes.
        stim = mk(1'b1, 1'b0, 32'h11223344, 4'hF, 4'hF, 1'b0, 2'd0, 1'b0, 2'd0);
        cycle();
        checkOutput("stable.no_err_yet", 64'(d0_err), 64'h0);
        checkOutput("stable.stall_sat", 64'(d0_stall), 64'h1);
        stim.tdata = 32'h11223345;
        cycle();
        checkOutput("stable.err", 64'(d0_err), 64'h01);
        checkOutput("stable.first_err", 64'(d0_ferr), 64'h0);
        stim.tready = 1'b1;
        cycle();
        stim = idle(1'b1);
        cycle();
        checkOutput("clear.err", 64'(d0_err), 64'h0);
        // Same change confined to an unkept byte is not an error.
        stim = mk(1'b1, 1'b0, 32'h11223344, 4'hE, 4'hE, 1'b0, 2'd0, 1'b0, 2'd0);
        cycle();
        stim.tdata = 32'h11223345;
        cycle();
        checkOutput("stable.unkept", 64'(d0_err), 64'h0);
        stim.tready = 1'b1;
        cycle();
        checkOutput("ch0.count7", 64'(d0_bc), 64'd7);

        // Packet-size limit on channel 2.
        stim = idle(1'b1);
        cycle();
        stim = mk(1'b1, 1'b1, 32'hDEADBEEF, 4'hF, 4'hF, 1'b0, 2'd2, 1'b0, 2'd2);
        cycle();
        checkOutput("maxpkt.beat1", 64'(l_err), 64'h0);
        cycle();
        checkOutput("maxpkt.at_limit", 64'(l_err), 64'h0);
        checkOutput("maxpkt.count8", 64'(l_bc), 64'd8);
        cycle();
        checkOutput("maxpkt.err", 64'(l_err), 64'h04);
        checkOutput("maxpkt.first_err", 64'(l_ferr), 64'h2);
        checkOutput("maxpkt.first_dest", 64'(l_fdest), 64'h2);
        i_sel = 2'd0; stim.sel = 2'd0;
        #1 checkOutput("maxpkt.ch0_kept", 64'(l_bc), 64'd7);
        i_sel = 2'd1; stim.sel = 2'd1;
        #1 checkOutput("maxpkt.ch1_kept", 64'(l_bc), 64'd0);
        stim = mk(1'b1, 1'b1, 32'hDEADBEEF, 4'hF, 4'hF, 1'b1, 2'd2, 1'b0, 2'd2);
        cycle();

        // Stall limit: four stalled cycles on channel 3.
        stim = idle(1'b1);
        cycle();
        stim = mk(1'b1, 1'b0, 32'h55AA55AA, 4'hF, 4'hF, 1'b0, 2'd3, 1'b0, 2'd3);
        for (int i = 1; i <= 4; i++) begin
            cycle();
            if (i <= 3) checkOutput($sformatf("stall.count%0d", i), 64'(l_stall), 64'(i));
            checkOutput($sformatf("stall.err%0d", i), 64'(l_err), (i == 4) ? 64'h10 : 64'h0);
        end
        checkOutput("stall.first_err", 64'(l_ferr), 64'h4);
        stim.tready = 1'b1;
        cycle();
        checkOutput("stall.released", 64'(l_stall), 64'h0);

        // Build 12 bytes on channel 0, then reset mid-packet.
        stim = mk(1'b1, 1'b1, 32'h0, 4'h0, 4'h0, 1'b1, 2'd0, 1'b0, 2'd0);
        cycle();
        stim = mk(1'b1, 1'b1, 32'h12345678, 4'hF, 4'hF, 1'b0, 2'd0, 1'b0, 2'd0);
        repeat (3) cycle();
        checkOutput("midpkt.count12", 64'(d0_bc), 64'd12);
        #2;
        resetDut();

        // Valid on the first edge after reset with a reserved lane.
        stim = mk(1'b1, 1'b1, 32'h0, 4'h0, 4'h1, 1'b0, 2'd0, 1'b0, 2'd0);
        cycle();
        checkOutput("rstvalid.d0_err", 64'(d0_err), 64'h22);
        checkOutput("rstvalid.d0_first", 64'(d0_ferr), 64'h1);
        checkOutput("rstvalid.lim_err", 64'(l_err), 64'h22);
        stim = idle(1'b1);
        cycle();
        checkOutput("rstvalid.cleared", 64'({d0_err, l_err}), 64'h0);

        // Randomized traffic against the model, with one reset partway through.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                @(negedge i_aclk);
                #1;
                resetDut();
            end
            randomStim();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
